// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, DATA_W bits LSB first, optional parity, 1/2 stop.
// Ports: clk, reset (async, high), s_valid/s_ready/s_data/s_err handshake,
//        cfg_parity (00/11 none, 01 even, 10 odd), cfg_stop2, tx, busy.
// Build option: define UART_TX_ERR_INJ_EN to let s_err invert the parity bit.
module uart_tx_frame #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_err,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
    output logic              tx,
    output logic              busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shr_q, shr_d;
    logic              par_q, par_d;
    logic              par_en_q, par_en_d;
    logic              par_odd_q, par_odd_d;
    logic              stop2_q, stop2_d;
    logic              stop_hi_q, stop_hi_d;
    logic              tx_q, tx_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;

    logic accept;
    logic term;
    logic par_bit;

    assign accept = (state_q == IDLE) && s_valid && s_ready_q;
    assign term   = (cnt_q == CNT_MAX);

`ifdef UART_TX_ERR_INJ_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = s_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Latched s_err flips the parity bit to provoke a receiver error
    assign par_bit = par_q ^ par_odd_q ^ err_q;
`else
    logic unused_s_err;
    assign unused_s_err = s_err;
    assign par_bit      = par_q ^ par_odd_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shr_d     = shr_q;
        par_d     = par_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        stop2_d   = stop2_q;
        stop_hi_d = stop_hi_q;
        tx_d      = tx_q;
        s_ready_d = s_ready_q;
        busy_d    = busy_q;

        unique case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                s_ready_d = 1'b1;
                cnt_d     = '0;
                if (accept) begin
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    s_ready_d = 1'b0;
                    shr_d     = s_data;
                    idx_d     = '0;
                    par_d     = 1'b0;
                    par_en_d  = ^cfg_parity;
                    par_odd_d = (cfg_parity == 2'b10);
                    stop2_d   = cfg_stop2;
                    stop_hi_d = 1'b0;
                end
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (term) begin
                    cnt_d   = '0;
                    state_d = DATA;
                    tx_d    = shr_q[0];
                    shr_d   = {1'b0, shr_q[DATA_W-1:1]};
                    par_d   = par_q ^ shr_q[0];
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (term) begin
                    cnt_d = '0;
                    if (idx_q == IDX_MAX) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Shift register front is always data[idx+1]
                        idx_d = idx_q + 1'b1;
                        tx_d  = shr_q[0];
                        shr_d = {1'b0, shr_q[DATA_W-1:1]};
                        par_d = par_q ^ shr_q[0];
                    end
                end
            end
            PARITY: begin
                cnt_d = cnt_q + 1'b1;
                if (term) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                cnt_d = cnt_q + 1'b1;
                tx_d  = 1'b1;
                if (term) begin
                    cnt_d = '0;
                    if (stop2_q && !stop_hi_q) begin
                        stop_hi_d = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        s_ready_d = 1'b1;
                        busy_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shr_q     <= '0;
            par_q     <= 1'b0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            stop_hi_q <= 1'b0;
            tx_q      <= 1'b1;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shr_q     <= shr_d;
            par_q     <= par_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            stop2_q   <= stop2_d;
            stop_hi_q <= stop_hi_d;
            tx_q      <= tx_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
        end
    end

    assign tx      = tx_q;
    assign s_ready = s_ready_q;
    assign busy    = busy_q;

endmodule
